ps2_host_tx: RTL

Host-to-device PS/2 transmitter: sends one command byte (e.g. keyboard LED/reset commands) to a PS/2 device over the shared open-collector clock/data pair. Runs the full host request-to-send sequence: clock inhibit, start, 8 data bits LSB first, odd parity, stop, device ACK. Sits beside the PS/2 receiver in the peripheral block. Both share the bidirectional pins through top-level tristate buffers driven by this block's output-enable signals.

---
 rtl/ps2_host_tx.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Runs the request-to-send sequence: clock inhibit, start bit, eight data
// bits LSB first, odd parity, stop bit and device ACK. It drives the shared
// open-collector pins only through the two output-enable signals.
// Optional build macro PS2_TX_TIMEOUT_EN adds a watchdog that aborts a frame
// when the device stops clocking. The watchdog runs from clock release
// until the lines go idle.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       done,
    output logic       err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        WAIT_IDLE,
        FINISH
    } state_t;

    state_t           state_reg, state_next;
    logic [INH_W-1:0] inh_cnt_reg, inh_cnt_next;
    logic [3:0]       edge_cnt_reg, edge_cnt_next;
    logic [7:0]       shift_reg, shift_next;
    logic             parity_reg, parity_next;
    logic             data_oe_reg, data_oe_next;
    logic             nack_reg, nack_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;

    // Synchronised pin levels: bit 1 is the clock, bit 0 is the data.
    logic [1:0] pin_raw;
    logic [1:0] pin_sync;
    logic       clk_prev_reg;
    logic       clk_s;
    logic       data_s;
    logic       fall;

    assign pin_raw = {ps2_clk_in, ps2_data_in};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            // Two-flop synchroniser per pin. Its reset value is the idle-high bus level.
            always_ff @(posedge clk) begin
                if (rst) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                end else begin
                    meta_reg <= pin_raw[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign pin_sync[gi] = sync_reg;
        end
    endgenerate

    assign clk_s  = pin_sync[1];
    assign data_s = pin_sync[0];

    // Delayed copy of the synchronised clock for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_prev_reg <= 1'b1;
        end else begin
            clk_prev_reg <= clk_s;
        end
    end

    assign fall = clk_prev_reg & ~clk_s;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wdog_reg;
    logic            wdog_active;

    assign wdog_active = (state_reg == SEND) || (state_reg == WAIT_IDLE);

    // Watchdog counts every cycle spent waiting on the device and clears otherwise.
    always_ff @(posedge clk) begin
        if (rst || !wdog_active) begin
            wdog_reg <= '0;
        end else begin
            wdog_reg <= wdog_reg + 1'b1;
        end
    end
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            inh_cnt_reg  <= '0;
            edge_cnt_reg <= '0;
            shift_reg    <= '0;
            parity_reg   <= 1'b0;
            data_oe_reg  <= 1'b0;
            nack_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            inh_cnt_reg  <= inh_cnt_next;
            edge_cnt_reg <= edge_cnt_next;
            shift_reg    <= shift_next;
            parity_reg   <= parity_next;
            data_oe_reg  <= data_oe_next;
            nack_reg     <= nack_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
        end
    end

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_next    = state_reg;
        inh_cnt_next  = inh_cnt_reg;
        edge_cnt_next = edge_cnt_reg;
        shift_next    = shift_reg;
        parity_next   = parity_reg;
        data_oe_next  = data_oe_reg;
        nack_next     = nack_reg;
        done_next     = 1'b0;
        err_next      = 1'b0;
        case (state_reg)
            IDLE: begin
                data_oe_next  = 1'b0;
                inh_cnt_next  = '0;
                edge_cnt_next = '0;
                if (tx_valid) begin
                    shift_next  = tx_data;
                    parity_next = ~^tx_data;
                    state_next  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_cnt_reg == INH_LAST) begin
                    // Data goes low together with the RTS cycle; this is the start bit.
                    data_oe_next = 1'b1;
                    state_next   = RTS;
                end else begin
                    inh_cnt_next = inh_cnt_reg + 1'b1;
                end
            end
            RTS: begin
                edge_cnt_next = '0;
                state_next    = SEND;
            end
            SEND: begin
                if (fall) begin
                    edge_cnt_next = edge_cnt_reg + 4'd1;
                    if (edge_cnt_reg < 4'd8) begin
                        data_oe_next = ~shift_reg[edge_cnt_reg[2:0]];
                    end else if (edge_cnt_reg == 4'd8) begin
                        data_oe_next = ~parity_reg;
                    end else if (edge_cnt_reg == 4'd9) begin
                        data_oe_next = 1'b0;
                    end else begin
                        // Eleventh edge: the device pulls data low to acknowledge.
                        nack_next  = data_s;
                        state_next = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    done_next  = ~nack_reg;
                    err_next   = nack_reg;
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
`ifdef PS2_TX_TIMEOUT_EN
        if (wdog_active && (wdog_reg == WD_LAST)) begin
            data_oe_next = 1'b0;
            done_next    = 1'b0;
            err_next     = 1'b1;
            state_next   = FINISH;
        end
`endif
    end

    assign tx_ready    = (state_reg == IDLE);
    assign ps2_clk_oe  = (state_reg == INHIBIT) || (state_reg == RTS);
    assign ps2_data_oe = data_oe_reg;
    assign done        = done_reg;
    assign err         = err_reg;

endmodule
